// File: rtl/register_file.sv
// RV32I integer register file with a one-bit-per-register pending-write scoreboard.
// Two combinational read ports with optional write-first forwarding; x0 reads as zero.
module register_file #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32,
  parameter int BYPASS_EN = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [$clog2(REG_COUNT)-1:0] rs1_read_index,
  output logic [XLEN-1:0]              rs1_read_data,
  output logic                         rs1_busy,
  input  logic [$clog2(REG_COUNT)-1:0] rs2_read_index,
  output logic [XLEN-1:0]              rs2_read_data,
  output logic                         rs2_busy,
  input  logic                         rd_reserve_enable,
  input  logic [$clog2(REG_COUNT)-1:0] rd_reserve_index,
  input  logic                         rd_write_enable,
  input  logic [$clog2(REG_COUNT)-1:0] rd_write_index,
  input  logic [XLEN-1:0]              rd_write_data,
  output logic                         busy_any
);

  localparam int IW = $clog2(REG_COUNT);

  logic [XLEN-1:0]      regs_q [REG_COUNT];
  logic [XLEN-1:0]      regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  logic wb_valid;
  logic byp1, byp2;

  assign wb_valid = rd_write_enable && (rd_write_index != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_valid) regs_d[rd_write_index] = rd_write_data;
    regs_d[0] = '0;
  end

  // A reservation beats a same-cycle write-back: the newer producer owns the register.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < REG_COUNT; i++) begin
      if (rd_reserve_enable && (rd_reserve_index == IW'(i)))
        busy_d[i] = 1'b1;
      else if (rd_write_enable && (rd_write_index == IW'(i)))
        busy_d[i] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
    end
  end

  // Forwarding is suppressed while in reset so outputs read zero immediately.
  always_comb begin
    byp1 = (BYPASS_EN != 0) && rst_n && wb_valid && (rd_write_index == rs1_read_index);
    byp2 = (BYPASS_EN != 0) && rst_n && wb_valid && (rd_write_index == rs2_read_index);

    if (rs1_read_index == '0) rs1_read_data = '0;
    else if (byp1)            rs1_read_data = rd_write_data;
    else                      rs1_read_data = regs_q[rs1_read_index];

    if (rs2_read_index == '0) rs2_read_data = '0;
    else if (byp2)            rs2_read_data = rd_write_data;
    else                      rs2_read_data = regs_q[rs2_read_index];

    rs1_busy = busy_q[rs1_read_index] && !byp1;
    rs2_busy = busy_q[rs2_read_index] && !byp2;
  end

  assign busy_any = |busy_q[REG_COUNT-1:1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: one instance with forwarding, one without,
// sharing the same stimulus.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_read_index, rs2_read_index, rd_reserve_index, rd_write_index;
  logic        rd_reserve_enable, rd_write_enable;
  logic [31:0] rd_write_data;

  logic [31:0] rs1_read_data, rs2_read_data;
  logic        rs1_busy, rs2_busy, busy_any;
  logic [31:0] nb_rs1_read_data, nb_rs2_read_data;
  logic        nb_rs1_busy, nb_rs2_busy, nb_busy_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_read_index(rs1_read_index), .rs1_read_data(rs1_read_data), .rs1_busy(rs1_busy),
    .rs2_read_index(rs2_read_index), .rs2_read_data(rs2_read_data), .rs2_busy(rs2_busy),
    .rd_reserve_enable(rd_reserve_enable), .rd_reserve_index(rd_reserve_index),
    .rd_write_enable(rd_write_enable), .rd_write_index(rd_write_index),
    .rd_write_data(rd_write_data), .busy_any(busy_any)
  );

  register_file #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(0)) dut_nb (
    .clk(clk), .rst_n(rst_n),
    .rs1_read_index(rs1_read_index), .rs1_read_data(nb_rs1_read_data), .rs1_busy(nb_rs1_busy),
    .rs2_read_index(rs2_read_index), .rs2_read_data(nb_rs2_read_data), .rs2_busy(nb_rs2_busy),
    .rd_reserve_enable(rd_reserve_enable), .rd_reserve_index(rd_reserve_index),
    .rd_write_enable(rd_write_enable), .rd_write_index(rd_write_index),
    .rd_write_data(rd_write_data), .busy_any(nb_busy_any)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let inputs be changed away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_reserve_enable = 1'b0;
    rd_write_enable   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rs1_read_index = 5'd0; rs2_read_index = 5'd0;
    rd_reserve_enable = 1'b0; rd_reserve_index = 5'd0;
    rd_write_enable = 1'b0; rd_write_index = 5'd0; rd_write_data = '0;
    #3;
    rs1_read_index = 5'd5;
    #1;
    check("reset_rs1_data", rs1_read_data, 32'h0);
    check("reset_busy_any", {31'b0, busy_any}, 32'h0);
    #3 rst_n = 1'b1;
    tick();

    // Reset hold: write x5, reserve x6, then async reset mid-cycle
    rd_write_enable = 1'b1; rd_write_index = 5'd5; rd_write_data = 32'hDEADBEEF;
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd6;
    tick(); idle();
    #1;
    check("x5_stored", rs1_read_data, 32'hDEADBEEF);
    check("busy_any_before_rst", {31'b0, busy_any}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_x5", rs1_read_data, 32'h0);
    check("async_rst_busy_any", {31'b0, busy_any}, 32'h0);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_x5", rs1_read_data, 32'h0);

    // x0 guard
    rs1_read_index = 5'd0; rs2_read_index = 5'd0;
    rd_write_enable = 1'b1; rd_write_index = 5'd0; rd_write_data = 32'h12345678;
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd0;
    #1;
    check("x0_bypass_rs1", rs1_read_data, 32'h0);
    check("x0_bypass_rs2", rs2_read_data, 32'h0);
    tick(); idle();
    #1;
    check("x0_rs1", rs1_read_data, 32'h0);
    check("x0_rs2", rs2_read_data, 32'h0);
    check("x0_rs1_busy", {31'b0, rs1_busy}, 32'h0);
    check("x0_busy_any", {31'b0, busy_any}, 32'h0);

    // Bypass vs no-bypass on x7
    rs1_read_index = 5'd7;
    rd_write_enable = 1'b1; rd_write_index = 5'd7; rd_write_data = 32'hA5A5A5A5;
    #1;
    check("byp_rs1_N", rs1_read_data, 32'hA5A5A5A5);
    check("nobyp_rs1_N", nb_rs1_read_data, 32'h0);
    tick(); idle();
    #1;
    check("byp_rs1_N1", rs1_read_data, 32'hA5A5A5A5);
    check("nobyp_rs1_N1", nb_rs1_read_data, 32'hA5A5A5A5);

    // Scoreboard on x3
    rs2_read_index = 5'd3;
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd3;
    #1;
    check("sb_busy_c1", {31'b0, rs2_busy}, 32'h0);
    tick(); idle();
    #1;
    check("sb_busy_c2", {31'b0, rs2_busy}, 32'h1);
    check("sb_busy_any_c2", {31'b0, busy_any}, 32'h1);
    tick();
    tick();
    check("sb_busy_c4_pre", {31'b0, rs2_busy}, 32'h1);
    rd_write_enable = 1'b1; rd_write_index = 5'd3; rd_write_data = 32'h55;
    #1;
    check("sb_busy_c4", {31'b0, rs2_busy}, 32'h0);
    check("sb_data_c4", rs2_read_data, 32'h55);
    check("sb_nb_busy_c4", {31'b0, nb_rs2_busy}, 32'h1);
    check("sb_nb_data_c4", nb_rs2_read_data, 32'h0);
    tick(); idle();
    #1;
    check("sb_busy_c5", {31'b0, rs2_busy}, 32'h0);
    check("sb_nb_busy_c5", {31'b0, nb_rs2_busy}, 32'h0);
    check("sb_busy_any_c5", {31'b0, busy_any}, 32'h0);
    check("sb_data_c5", rs2_read_data, 32'h55);

    // Collision: reserve and write-back x9 in the same cycle
    rs1_read_index = 5'd9;
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd9;
    rd_write_enable = 1'b1; rd_write_index = 5'd9; rd_write_data = 32'h11;
    tick(); idle();
    #1;
    check("coll_data", rs1_read_data, 32'h11);
    check("coll_busy", {31'b0, rs1_busy}, 32'h1);
    rd_write_enable = 1'b1; rd_write_index = 5'd9; rd_write_data = 32'h22;
    #1;
    check("coll_wb2_fwd_busy", {31'b0, rs1_busy}, 32'h0);
    check("coll_wb2_fwd_data", rs1_read_data, 32'h22);
    tick(); idle();
    #1;
    check("coll_cleared", {31'b0, rs1_busy}, 32'h0);
    check("coll_busy_any", {31'b0, busy_any}, 32'h0);

    // Dual port on x4
    rd_write_enable = 1'b1; rd_write_index = 5'd4; rd_write_data = 32'hFFFFFFFF;
    tick(); idle();
    rs1_read_index = 5'd4; rs2_read_index = 5'd4;
    #1;
    check("dual_rs1", rs1_read_data, 32'hFFFFFFFF);
    check("dual_rs2", rs2_read_data, 32'hFFFFFFFF);
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd4;
    tick(); idle();
    #1;
    check("dual_rs1_busy", {31'b0, rs1_busy}, 32'h1);
    check("dual_rs2_busy", {31'b0, rs2_busy}, 32'h1);

    // Reserve x10 and write-back x4 in the same cycle: both effects land
    rs2_read_index = 5'd10;
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd10;
    rd_write_enable = 1'b1; rd_write_index = 5'd4; rd_write_data = 32'h1;
    tick(); idle();
    #1;
    check("split_x4_busy", {31'b0, rs1_busy}, 32'h0);
    check("split_x4_data", rs1_read_data, 32'h1);
    check("split_x10_busy", {31'b0, rs2_busy}, 32'h1);

    // Re-reserve already busy x10, then one write-back clears it
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd10;
    tick(); idle();
    #1;
    check("rereserve_busy", {31'b0, rs2_busy}, 32'h1);
    rd_write_enable = 1'b1; rd_write_index = 5'd10; rd_write_data = 32'h77;
    tick(); idle();
    #1;
    check("rereserve_cleared", {31'b0, rs2_busy}, 32'h0);
    check("rereserve_data", rs2_read_data, 32'h77);

    // Reset mid-operation discards a pending reservation
    rd_reserve_enable = 1'b1; rd_reserve_index = 5'd12;
    tick(); idle();
    #1;
    check("pre_rst2_busy_any", {31'b0, busy_any}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst2_busy_any", {31'b0, busy_any}, 32'h0);
    check("rst2_x4", rs1_read_data, 32'h0);
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
